// File: rtl/acc_job_scheduler.sv
`default_nettype none
// ============================================================================
// acc_job_scheduler : queues job descriptors, launches them one at a time on
// the accelerator and returns each result. Option: SCHED_WATCHDOG_EN.
// Revision: 1.0
// ============================================================================
module acc_job_scheduler #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int MAX_ELEMS      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_read_base,
  input  logic [63:0] job_write_base,
  input  logic [63:0] job_num_read,
  input  logic [63:0] job_size,
  output logic        acc_start,
  output logic [63:0] acc_read_base,
  output logic [63:0] acc_write_base,
  output logic [63:0] acc_num_read,
  output logic [63:0] acc_read_size,
  input  logic        acc_done,
  input  logic [31:0] acc_returnvalue,
  output logic        acc_kill,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_status,
  output logic        busy,
  output logic [31:0] jobs_completed
);

  localparam int c_ptr_w = $clog2(QUEUE_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(QUEUE_DEPTH);

  typedef struct packed {
    logic [63:0] read_base;
    logic [63:0] write_base;
    logic [63:0] num_read;
    logic [63:0] size;
  } job_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  job_t                 fifo_q [QUEUE_DEPTH];
  job_t                 fifo_d [QUEUE_DEPTH];
  logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]   count_q, count_d;
  job_t                 acc_job_q, acc_job_d;
  logic                 acc_start_q, acc_start_d;
  logic                 acc_kill_q, acc_kill_d;
  logic                 res_valid_q, res_valid_d;
  logic                 idle_hold_q, idle_hold_d;
  logic [31:0]          res_data_q, res_data_d;
  logic [1:0]           res_status_q, res_status_d;
  logic [31:0]          jobs_completed_q, jobs_completed_d;
  logic                 push, pop, head_legal;
  job_t                 head;

`ifdef SCHED_WATCHDOG_EN
  logic [31:0]          wd_cnt_q, wd_cnt_d;
  logic                 wd_expire;
  assign wd_expire = (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic                 unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign job_ready  = (count_q != c_full);
  assign push       = job_valid && job_ready;
  assign head       = fifo_q[rd_ptr_q];
  assign head_legal = (head.num_read != 64'd0) && (head.num_read <= 64'(MAX_ELEMS));

  always_comb begin
    state_d          = state_q;
    fifo_d           = fifo_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    acc_job_d        = acc_job_q;
    acc_start_d      = acc_start_q;
    acc_kill_d       = 1'b0;
    res_valid_d      = res_valid_q;
    res_data_d       = res_data_q;
    res_status_d     = res_status_q;
    jobs_completed_d = jobs_completed_q;
    idle_hold_d      = 1'b0;
    pop              = 1'b0;
`ifdef SCHED_WATCHDOG_EN
    wd_cnt_d         = wd_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // idle_hold_q enforces one empty IDLE cycle after each retirement
        if (count_q != '0 && !idle_hold_q) begin
          pop = 1'b1;
          if (head_legal) begin
            acc_job_d   = head;
            acc_start_d = 1'b1;
            state_d     = ST_RUN;
`ifdef SCHED_WATCHDOG_EN
            wd_cnt_d    = '0;
`endif
          end else begin
            res_valid_d  = 1'b1;
            res_data_d   = '0;
            res_status_d = 2'd1;
            state_d      = ST_RESULT;
          end
        end
      end
      ST_RUN: begin
        acc_start_d = 1'b0;
        if (acc_done && !acc_start_q) begin
          res_valid_d  = 1'b1;
          res_data_d   = acc_returnvalue;
          res_status_d = 2'd0;
          state_d      = ST_RESULT;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (wd_expire) begin
          acc_kill_d   = 1'b1;
          res_valid_d  = 1'b1;
          res_data_d   = '0;
          res_status_d = 2'd2;
          state_d      = ST_RESULT;
        end
        wd_cnt_d = wd_cnt_q + 32'd1;
`endif
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d      = 1'b0;
          jobs_completed_d = jobs_completed_q + 32'd1;
          idle_hold_d      = 1'b1;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = '{job_read_base, job_write_base, job_num_read, job_size};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      acc_job_q        <= '0;
      acc_start_q      <= 1'b0;
      acc_kill_q       <= 1'b0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      res_status_q     <= '0;
      jobs_completed_q <= '0;
      idle_hold_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      acc_job_q        <= acc_job_d;
      acc_start_q      <= acc_start_d;
      acc_kill_q       <= acc_kill_d;
      res_valid_q      <= res_valid_d;
      res_data_q       <= res_data_d;
      res_status_q     <= res_status_d;
      jobs_completed_q <= jobs_completed_d;
      idle_hold_q      <= idle_hold_d;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`endif

  assign acc_start      = acc_start_q;
  assign acc_kill       = acc_kill_q;
  assign acc_read_base  = acc_job_q.read_base;
  assign acc_write_base = acc_job_q.write_base;
  assign acc_num_read   = acc_job_q.num_read;
  assign acc_read_size  = acc_job_q.size;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_status     = res_status_q;
  assign jobs_completed = jobs_completed_q;
  assign busy           = (count_q != '0) || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_acc_job_scheduler.sv
`default_nettype none
// ============================================================================
// tb_acc_job_scheduler : randomized self-checking bench with an in-order job
// model and a behavioural accelerator. Revision: 1.0
// ============================================================================
module tb_acc_job_scheduler;
  localparam int QD = 4;
  localparam int ME = 32;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, job_valid, job_ready, acc_start, acc_done, acc_kill;
  logic        res_valid, res_ready, busy;
  logic [63:0] job_read_base, job_write_base, job_num_read, job_size;
  logic [63:0] acc_read_base, acc_write_base, acc_num_read, acc_read_size;
  logic [31:0] acc_returnvalue, res_data, jobs_completed;
  logic [1:0]  res_status;

  acc_job_scheduler #(.QUEUE_DEPTH(QD), .MAX_ELEMS(ME), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_read_base(job_read_base), .job_write_base(job_write_base),
    .job_num_read(job_num_read), .job_size(job_size), .acc_start(acc_start),
    .acc_read_base(acc_read_base), .acc_write_base(acc_write_base),
    .acc_num_read(acc_num_read), .acc_read_size(acc_read_size),
    .acc_done(acc_done), .acc_returnvalue(acc_returnvalue), .acc_kill(acc_kill),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_status(res_status), .busy(busy), .jobs_completed(jobs_completed)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] rb, wb, nr, sz; bit tmo; } desc_t;
  typedef struct { logic [63:0] rb, wb, nr, sz; int cyc; } launch_t;

  desc_t       exp_q[$];
  launch_t     launch_q[$];
  logic [31:0] rv_q[$];
  logic [33:0] got_q[$];
  int errors = 0, checks = 0, n_retired = 0, cyc = 0, kill_seen = 0;
  int acc_lat = 5;
  bit acc_hang = 0, spurious = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (acc_kill === 1'b1) kill_seen <= kill_seen + 1;
  always @(negedge clk)
    if (reset === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1)
      got_q.push_back({res_status, res_data});

  // Behavioural accelerator: done arrives acc_lat cycles after the start edge
  initial begin : accel
    int cnt;
    cnt = 0;
    acc_done = 1'b0;
    acc_returnvalue = '0;
    forever begin
      @(posedge clk); #2;
      acc_done = 1'b0;
      if (reset === 1'b1) cnt = 0;
      else begin
        if (acc_start === 1'b1) begin
          launch_q.push_back('{acc_read_base, acc_write_base, acc_num_read, acc_read_size, cyc});
          cnt = acc_hang ? 0 : acc_lat - 1;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            acc_done = 1'b1;
            acc_returnvalue = $urandom;
            rv_q.push_back(acc_returnvalue);
          end
        end
        if (spurious) begin
          spurious = 0;
          if (!acc_done) begin acc_done = 1'b1; acc_returnvalue = $urandom; end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic desc_t rand_desc(input logic [63:0] nr);
    desc_t d;
    d.rb = {$urandom, $urandom};
    d.wb = {$urandom, $urandom};
    d.nr = nr;
    d.sz = 64'($urandom_range(1, 8));
    d.tmo = 1'b0;
    return d;
  endfunction

  task automatic push_job(input desc_t d);
    int g = 0;
    job_valid = 1'b1;
    job_read_base = d.rb; job_write_base = d.wb; job_num_read = d.nr; job_size = d.sz;
    while (job_ready !== 1'b1 && g < 2000) begin tick(); g++; end
    if (g >= 2000) begin
      checks++; errors++;
      $display("FAIL push_wait job_ready=%b want=1 after %0d cycles", job_ready, g);
    end
    tick();
    job_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  // Retire every submitted job through the in-order model and compare
  task automatic drain_check(input int budget);
    int g = 0;
    logic [33:0] got, want;
    launch_t l;
    desc_t d;
    bit legal;
    while (got_q.size() < exp_q.size() && g < budget) begin tick(); g++; end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL drain_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      d = exp_q.pop_front();
      legal = (d.nr >= 64'd1) && (d.nr <= 64'(ME));
      if (legal) begin
        checks++;
        if (launch_q.size() == 0) begin
          errors++; $display("FAIL launch_missing got=none want_rb=%h", d.rb);
        end else begin
          l = launch_q.pop_front();
          if ({l.rb, l.wb, l.nr, l.sz} !== {d.rb, d.wb, d.nr, d.sz}) begin
            errors++;
            $display("FAIL launch_params got=%h/%h/%0d/%0d want=%h/%h/%0d/%0d",
                     l.rb, l.wb, l.nr, l.sz, d.rb, d.wb, d.nr, d.sz);
          end
        end
        if (d.tmo) want = {2'd2, 32'd0};
        else want = {2'd0, (rv_q.size() > 0) ? rv_q.pop_front() : 32'hxxxx_xxxx};
      end else begin
        want = {2'd1, 32'd0};
      end
      n_retired++;
      got = (got_q.size() > 0) ? got_q.pop_front() : 34'hx;
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL result got=st%0d/%h want=st%0d/%h", got[33:32], got[31:0], want[33:32], want[31:0]);
      end
    end
    checks++;
    if (launch_q.size() != 0) begin
      errors++; $display("FAIL extra_launch got=%0d want=0", launch_q.size());
    end
    tick();
    checks++;
    if (jobs_completed !== 32'(n_retired)) begin
      errors++; $display("FAIL jobs_completed got=%0d want=%0d", jobs_completed, n_retired);
    end
    got_q.delete(); rv_q.delete(); launch_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({job_ready, busy, acc_start, acc_kill, res_valid} !== 5'b10000) begin
      errors++; $display("FAIL %s_flags got=%b want=10000", tag, {job_ready, busy, acc_start, acc_kill, res_valid});
    end
    checks++;
    if ({res_data, res_status, jobs_completed} !== 66'd0) begin
      errors++; $display("FAIL %s_result got=%h/%0d/%0d want=0/0/0", tag, res_data, res_status, jobs_completed);
    end
    checks++;
    if ({acc_read_base, acc_write_base, acc_num_read, acc_read_size} !== 256'd0) begin
      errors++; $display("FAIL %s_acc_params got=%h/%h/%0d/%0d want=all zero", tag,
                         acc_read_base, acc_write_base, acc_num_read, acc_read_size);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    desc_t d;
    res_ready = 1'b1; acc_lat = 20;
    d = '{64'h1000, 64'h2000, 64'd8, 64'd4, 1'b0};
    push_job(d);
    checks++;
    if (acc_start !== 1'b0) begin errors++; $display("FAIL single_start_early got=%b want=0", acc_start); end
    tick();
    checks++;
    if (acc_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b want=1", acc_start); end
    checks++;
    if ({acc_read_base, acc_write_base, acc_num_read, acc_read_size} !== {64'h1000, 64'h2000, 64'd8, 64'd4}) begin
      errors++; $display("FAIL single_params got=%h/%h/%0d/%0d want=1000/2000/8/4",
                         acc_read_base, acc_write_base, acc_num_read, acc_read_size);
    end
    tick();
    checks++;
    if (acc_start !== 1'b0) begin errors++; $display("FAIL single_start_width got=%b want=0", acc_start); end
    drain_check(100);
  endtask

  task automatic test_back_to_back();
    int g = 0;
    res_ready = 1'b1;
    acc_lat = $urandom_range(3, 8);
    for (int i = 0; i < 5; i++) push_job(rand_desc(64'($urandom_range(1, ME))));
    checks++;
    if ({job_ready, busy} !== 2'b01) begin
      errors++; $display("FAIL b2b_full got=ready%b/busy%b want=ready0/busy1", job_ready, busy);
    end
    while (got_q.size() < 5 && g < 200) begin tick(); g++; end
    for (int i = 0; i + 1 < launch_q.size(); i++) begin
      checks++;
      if (launch_q[i+1].cyc - launch_q[i].cyc != acc_lat + 3) begin
        errors++; $display("FAIL b2b_period got=%0d want=%0d", launch_q[i+1].cyc - launch_q[i].cyc, acc_lat + 3);
      end
    end
    drain_check(20);
  endtask

  task automatic test_illegal();
    res_ready = 1'b1; acc_lat = 4;
    push_job(rand_desc(64'd0));
    push_job(rand_desc(64'd33));
    push_job(rand_desc({$urandom, $urandom} | 64'h1_0000_0000));
    push_job(rand_desc(64'd32));
    push_job(rand_desc(64'd1));
    drain_check(200);
  endtask

  task automatic test_backpressure();
    int g = 0;
    logic [290:0] snap, now;
    res_ready = 1'b0; acc_lat = 4;
    push_job(rand_desc(64'($urandom_range(1, ME))));
    push_job(rand_desc(64'($urandom_range(1, ME))));
    while (res_valid !== 1'b1 && g < 60) begin tick(); g++; end
    snap = {res_valid, res_data, res_status, acc_read_base, acc_write_base, acc_num_read, acc_read_size};
    checks++;
    if (snap[290] !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b want=1", snap[290]); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) spurious = 1;
      tick();
      now = {res_valid, res_data, res_status, acc_read_base, acc_write_base, acc_num_read, acc_read_size};
      checks++;
      if (now !== snap || acc_start !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d got=%h start=%b want=%h start=0", i, now[290:256], acc_start, snap[290:256]);
      end
    end
    res_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (acc_start !== 1'b0) begin errors++; $display("FAIL bp_gap got=%b want=0", acc_start); end
    tick();
    checks++;
    if (acc_start !== 1'b1) begin errors++; $display("FAIL bp_relaunch got=%b want=1", acc_start); end
    drain_check(100);
  endtask

`ifdef SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    desc_t a, b;
    int g = 0, k0, lat;
    res_ready = 1'b1; acc_lat = 5; acc_hang = 1;
    k0 = kill_seen;
    a = rand_desc(64'($urandom_range(1, ME))); a.tmo = 1'b1;
    b = rand_desc(64'($urandom_range(1, ME)));
    push_job(a);
    push_job(b);
    tick();
    acc_hang = 0;
    while (acc_kill !== 1'b1 && g < 100) begin tick(); g++; end
    lat = (launch_q.size() > 0) ? cyc - launch_q[0].cyc : -1;
    checks++;
    if (acc_kill !== 1'b1 || lat != TO) begin
      errors++; $display("FAIL wd_latency got=%0d kill=%b want=%0d kill=1", lat, acc_kill, TO);
    end
    checks++;
    if ({res_valid, res_status, res_data} !== {1'b1, 2'd2, 32'd0}) begin
      errors++; $display("FAIL wd_result got=v%b/st%0d/%h want=v1/st2/0", res_valid, res_status, res_data);
    end
    tick();
    checks++;
    if (acc_kill !== 1'b0) begin errors++; $display("FAIL wd_kill_width got=%b want=0", acc_kill); end
    drain_check(100);
    checks++;
    if (kill_seen - k0 != 1) begin errors++; $display("FAIL wd_kill_count got=%0d want=1", kill_seen - k0); end
  endtask
`endif

  task automatic test_reset_mid_run();
    int k0;
    bit bad = 0;
    res_ready = 1'b1; acc_hang = 1;
    for (int i = 0; i < 3; i++) push_job(rand_desc(64'($urandom_range(1, ME))));
    tick();
    acc_hang = 0;
`ifdef SCHED_WATCHDOG_EN
    repeat (6) tick();
`else
    repeat (40) tick();
    checks++;
    if ({res_valid, acc_kill, busy} !== 3'b001 || kill_seen != 0) begin
      errors++; $display("FAIL hang_no_watchdog got=v%b/k%b/b%b/kills%0d want=v0/k0/b1/kills0",
                         res_valid, acc_kill, busy, kill_seen);
    end
`endif
    k0 = kill_seen;
    reset = 1'b1;
    tick();
    check_reset_values("midrun");
    reset = 1'b0;
    exp_q.delete(); launch_q.delete(); rv_q.delete(); got_q.delete();
    n_retired = 0;
    spurious = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b0 || acc_start !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad || kill_seen != k0) begin
      errors++; $display("FAIL post_reset_idle got=bad%b/kills%0d want=bad0/kills%0d", bad, kill_seen, k0);
    end
    acc_lat = 4;
    push_job(rand_desc(64'($urandom_range(1, ME))));
    drain_check(50);
  endtask

  initial begin
    reset = 1'b1; job_valid = 1'b0; res_ready = 1'b0;
    job_read_base = '0; job_write_base = '0; job_num_read = '0; job_size = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_backpressure();
`ifdef SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=still running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire

// File: doc/acc_job_scheduler.md
# acc_job_scheduler

Job scheduler for the read/compute/write accelerator wrapper. It queues job descriptors (read base, write base, element count, element size), launches them one at a time on the accelerator, and waits for its done pulse. It returns each job's 32-bit return value through a valid/ready result port. It sits between the host/control side and a single accelerator instance and is the only agent that drives the accelerator's launch parameters.

## Interface
Parameters:
- QUEUE_DEPTH, 4, job FIFO entries; power of two, 2..16
- MAX_ELEMS, 32, largest legal job_num_read (accelerator buffer size)
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN (used only with SCHED_WATCHDOG_EN)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- job_valid  in  1  descriptor offered
- job_ready  out  1  queue not full
- job_read_base  in  64  source base address
- job_write_base  in  64  destination base address
- job_num_read  in  64  element count
- job_size  in  64  element stride/size
- acc_start  out  1  one-cycle launch pulse
- acc_read_base / acc_write_base / acc_num_read / acc_read_size  out  64 each  launch parameters, held stable from start until the job retires
- acc_done  in  1  accelerator completion pulse
- acc_returnvalue  in  32  accelerator result, valid with acc_done
- acc_kill  out  1  one-cycle abort pulse on watchdog expiry
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  32  return value
- res_status  out  2  0 OK, 1 bad length, 2 timeout
- busy  out  1  queue non-empty or state not IDLE
- jobs_completed  out  32  retired-job counter

## Operation
- Reset: FIFO flushed; state IDLE. All outputs are 0, except job_ready=1 and busy=0. A reset during a job abandons it without pulsing acc_kill.
- Enqueue: a job is written on an edge where job_valid && job_ready. job_ready = !full, based on the registered count only. A pop in the same cycle does not make room.
- IDLE with queue non-empty: the head is popped.
  - Head legal (1 <= num_read <= MAX_ELEMS): acc_* registers load, acc_start<=1, state goes to RUN.
  - Head illegal: acc_start stays 0; res_valid<=1, res_data<=0, res_status<=1; state goes to RESULT.
- RUN: acc_start<=0 on the first edge. acc_done is ignored while acc_start is high.
  - On acc_done: res_data<=acc_returnvalue, res_status<=0, res_valid<=1; state goes to RESULT.
  - acc_done outside RUN is ignored.
- RESULT: res_valid holds until an edge with res_ready.
  - On that edge: res_valid<=0, jobs_completed+=1 (all statuses, wraps modulo 2^32), state goes to IDLE.
  - acc_* parameters hold until this edge.
- Counter arithmetic: FIFO pointers are log2(QUEUE_DEPTH) bits and wrap. Count is one bit wider.

## Timing
- Job accepted on edge E into an idle, empty scheduler: acc_start is high from E+1 to E+2, and acc_* are valid from E+1.
- acc_done high on edge D: res_valid high from D.
- Result handshake on edge H: the next job's acc_start rises at H+2 at the earliest (one IDLE cycle in between).
- Back-to-back throughput: one job per (accelerator latency + 3) cycles with res_ready tied high.
- Enqueue and dequeue on the same edge are both allowed when 0 < count < QUEUE_DEPTH; the count is unchanged.

## Configuration
- SCHED_WATCHDOG_EN defined: a 32-bit counter clears on entering RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES without acc_done: acc_kill pulses for one cycle, res_data<=0, res_status<=2, res_valid<=1, state goes to RESULT.
  - acc_done on the same edge as expiry wins (status 0).
- SCHED_WATCHDOG_EN undefined: no counter; acc_kill is tied 0; status 2 is never produced; RUN waits indefinitely.

## Test plan
- Single job (read 0x1000, write 0x2000, num 8, size 4); accelerator done 20 cycles after start with 0x1234 -> one acc_start pulse at E+1, acc_* equal to the descriptor, res_data=0x1234, status 0, jobs_completed=1.
- Push 5 jobs back-to-back with QUEUE_DEPTH=4 while the first is running -> job_ready low while the FIFO is full, all 5 executed in order, jobs_completed=5.
- Job with num_read 0, then num_read 33, then a legal job -> two results with status 1, no acc_start for the illegal jobs, third job launches normally.
- res_ready held low for 10 cycles after done -> res_valid, res_data and acc_* stable; no new acc_start until the handshake; a spurious acc_done meanwhile is ignored.
- With SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=16, accelerator never done -> acc_kill pulses once after 16 RUN cycles, status 2, next queued job launches.
- reset asserted mid-RUN with 2 jobs queued -> next edge: all outputs at reset values, queue empty, busy=0, later acc_done ignored.
